seg_display_arbiter: RTL and testbench
======================================

SEG_DISPLAY_ARBITER -- requirements
Module: seg_display_arbiter

Interface
REQ-001 SHALL have parameter PRESCALE, default 16: scan_tick period in clk cycles, legal values 2..65535.
REQ-002 SHALL have parameter DWELL, default 1024: maximum HOLD length in clk cycles per grant, legal values 2..2^20.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous reset, active-low.
REQ-005 req  in  4  per-source display request, level-sensitive; bit i = source i.
REQ-006 data0, data1, data2, data3  in  16 each  candidate display words, one per source.
REQ-007 gnt  out  4  one-hot grant, or all-zero when no source holds the display.
REQ-008 src_id  out  2  index of the current or most recent grantee.
REQ-009 disp_data  out  16  registered word driven to the 4-digit hex display driver.
REQ-010 busy  out  1  high while in HOLD.
REQ-011 scan_tick  out  1  one-cycle pulse, used as the digit-advance enable of the display driver.

Function
REQ-012 Prescaler: free-running counter SHALL pulse scan_tick for exactly 1 cycle every PRESCALE cycles; it SHALL be independent of the FSM.
REQ-013 FSM SHALL have exactly three states: IDLE, HOLD, RELEASE.
REQ-014 IDLE, req != 0:
- At the next edge, grant the round-robin winner: first set bit of req searching from (last+1) mod 4 upward, wrapping.
- On that edge: gnt = onehot(winner); src_id = winner; last = winner; disp_data = data[winner]; dwell counter = DWELL-1; state = HOLD.
- Grant latency: 1 cycle.
REQ-015 IDLE, req == 0: outputs SHALL hold; disp_data SHALL retain its last value.
REQ-016 HOLD:
- disp_data SHALL reload from data[src_id] every cycle (live view, 1-cycle lag).
- Dwell counter SHALL decrement every cycle.
REQ-017 HOLD SHALL go to RELEASE when either condition holds: dwell counter == 0 (HOLD lasts exactly DWELL cycles), or req[src_id] == 0 (early release, detected the same cycle).
REQ-018 RELEASE:
- Lasts exactly 1 cycle, then IDLE.
- gnt = 0 and busy = 0.
- disp_data and src_id frozen.
- Minimum gap between consecutive grants: 2 cycles.
REQ-019 A source still requesting at dwell expiry SHALL be re-granted only if no other source is requesting, which guarantees fairness.
REQ-020 gnt SHALL never have more than one bit set; busy SHALL equal |gnt.
REQ-021 Simultaneous requests SHALL resolve purely by the round-robin pointer; there is no fixed priority unless REQ-026 applies.

Reset
REQ-022 On rst_n low, immediately and without clk: gnt = 0, src_id = 0, disp_data = 16'h0000, busy = 0, scan_tick = 0, prescaler = 0, dwell counter = 0, last = 3, state = IDLE.
REQ-023 Reset asserted mid-HOLD SHALL abort the grant with no RELEASE cycle.
REQ-024 Reset deassertion SHALL be synchronous to clk; the first grant is evaluated on the first edge after release.

Configuration
REQ-025 Macro SEG_PREEMPT_EN SHALL select source-0 preemption.
REQ-026 With SEG_PREEMPT_EN defined: req[0] high while in HOLD with src_id != 0 SHALL force RELEASE at the next edge; the following IDLE SHALL grant source 0 regardless of the round-robin pointer.
REQ-027 Without SEG_PREEMPT_EN: no preemption; arbitration is pure round-robin per REQ-014 and REQ-017.

Verification (PRESCALE = 4, DWELL = 8)
REQ-028 Release reset, req = 0 -> scan_tick pulses at cycles 4, 8, 12; gnt = 0; disp_data = 16'h0000.
REQ-029 req = 4'b0010, data1 = 16'hBEEF -> gnt = 4'b0010 one cycle later; disp_data = BEEF; busy high for 8 cycles, then 1 RELEASE cycle, then re-grant of source 1.
REQ-030 req = 4'b1111 held, all data distinct -> grant order 0,1,2,3,0; each grant 8 cycles long; 2-cycle gap between grants.
REQ-031 Source 2 granted, data2 changes 1234 -> 5678 mid-HOLD; then req[2] drops at HOLD cycle 3 -> disp_data = 5678 one cycle after the change; RELEASE follows the drop; disp_data stays 5678 after release.
REQ-032 rst_n pulsed low at HOLD cycle 4 -> gnt, busy, and disp_data cleared immediately with no clk edge; next grant starts from source 0.
REQ-033 SEG_PREEMPT_EN defined, source 3 granted, req[0] rises at HOLD cycle 2 -> RELEASE next edge, then gnt = 4'b0001; without the macro, source 3 holds all 8 cycles.

Source files
------------

// File: rtl/seg_display_if.sv
// seg_display_if
//   Bundles the request/grant bus of seg_display_arbiter.
//   Signals:
//     req[3:0]        per-source display request (level)
//     data0..data3    candidate 16-bit display words, one per source
//     gnt[3:0]        one-hot grant, all-zero when nobody holds the display
//     src_id[1:0]     current or most recent grantee
//     disp_data[15:0] registered word for the 4-digit hex display driver
//     busy            high while a grant is held
//     scan_tick       one-cycle digit-advance pulse for the display driver
//   Modports: master = request side (sources), slave = arbiter.
interface seg_display_if;
  logic [3:0]  req;
  logic [15:0] data0;
  logic [15:0] data1;
  logic [15:0] data2;
  logic [15:0] data3;
  logic [3:0]  gnt;
  logic [1:0]  src_id;
  logic [15:0] disp_data;
  logic        busy;
  logic        scan_tick;

  modport master (
    output req, data0, data1, data2, data3,
    input  gnt, src_id, disp_data, busy, scan_tick
  );

  modport slave (
    input  req, data0, data1, data2, data3,
    output gnt, src_id, disp_data, busy, scan_tick
  );
endinterface

// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter
//   Round-robin arbiter that lets one of four sources own a 4-digit hex
//   display for at most DWELL cycles, plus a free-running scan prescaler.
//   Ports:
//     clk    sole clock, rising edge
//     rst_n  asynchronous active-low reset; deassertion is expected to be
//            synchronous to clk (synchronised upstream)
//     bus    seg_display_if.slave (req, data0..3 in; gnt, src_id,
//            disp_data, busy, scan_tick out)
//   Parameters:
//     PRESCALE  scan_tick period in clk cycles (2..65535)
//     DWELL     maximum grant length in clk cycles (2..2^20)
//   Optional feature:
//     SEG_PREEMPT_EN  when defined, a request from source 0 preempts any
//                     other holder and source 0 wins the next arbitration.
module seg_display_arbiter #(
  parameter int unsigned PRESCALE = 16,
  parameter int unsigned DWELL    = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  seg_display_if.slave bus
);

  localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [DW_W-1:0] DW_LOAD = DW_W'(DWELL - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  function automatic logic [15:0] pick_word(
    input logic [1:0]  idx,
    input logic [15:0] d0,
    input logic [15:0] d1,
    input logic [15:0] d2,
    input logic [15:0] d3
  );
    case (idx)
      2'd0:    pick_word = d0;
      2'd1:    pick_word = d1;
      2'd2:    pick_word = d2;
      default: pick_word = d3;
    endcase
  endfunction

  // Prescaler: free-running, unrelated to arbitration.
  logic [PS_W-1:0] ps_cnt;
  logic            scan_tick_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_cnt      <= '0;
      scan_tick_q <= 1'b0;
    end else begin
      scan_tick_q <= (ps_cnt == PS_LAST);
      ps_cnt      <= (ps_cnt == PS_LAST) ? '0 : ps_cnt + 1'b1;
    end
  end

  state_t          state, state_nxt;
  logic [3:0]      gnt_q, gnt_nxt;
  logic [1:0]      src_q, src_nxt;
  logic [1:0]      last_q, last_nxt;
  logic [15:0]     disp_q, disp_nxt;
  logic [DW_W-1:0] dwell_q, dwell_nxt;
  logic [1:0]      rr_win;
  logic [1:0]      win;
`ifdef SEG_PREEMPT_EN
  logic            pre_q, pre_nxt;
`endif

  // Round-robin search starting one past the last grantee. Scanning the
  // offsets downwards lets the nearest requester overwrite farther ones.
  always_comb begin
    rr_win = last_q;
    for (int k = 4; k >= 1; k--) begin
      if (bus.req[last_q + k[1:0]]) begin
        rr_win = last_q + k[1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gnt_q   <= '0;
      src_q   <= '0;
      last_q  <= 2'd3;
      disp_q  <= '0;
      dwell_q <= '0;
`ifdef SEG_PREEMPT_EN
      pre_q   <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      gnt_q   <= gnt_nxt;
      src_q   <= src_nxt;
      last_q  <= last_nxt;
      disp_q  <= disp_nxt;
      dwell_q <= dwell_nxt;
`ifdef SEG_PREEMPT_EN
      pre_q   <= pre_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt_q;
    src_nxt   = src_q;
    last_nxt  = last_q;
    disp_nxt  = disp_q;
    dwell_nxt = dwell_q;
    win       = rr_win;
`ifdef SEG_PREEMPT_EN
    pre_nxt   = pre_q;
    // A preempted holder hands the display straight to source 0, as long
    // as source 0 is still asking for it.
    if (pre_q && bus.req[0]) begin
      win = 2'd0;
    end
`endif

    unique case (state)
      IDLE: begin
        if (|bus.req) begin
          state_nxt = HOLD;
          gnt_nxt   = 4'b0001 << win;
          src_nxt   = win;
          last_nxt  = win;
          disp_nxt  = pick_word(win, bus.data0, bus.data1, bus.data2, bus.data3);
          dwell_nxt = DW_LOAD;
`ifdef SEG_PREEMPT_EN
          pre_nxt   = 1'b0;
`endif
        end
      end
      HOLD: begin
        // Live view of the holder's word, one cycle behind the source.
        disp_nxt = pick_word(src_q, bus.data0, bus.data1, bus.data2, bus.data3);
        if (dwell_q != '0) begin
          dwell_nxt = dwell_q - 1'b1;
        end
        if (dwell_q == '0 || !bus.req[src_q]) begin
          state_nxt = RELEASE;
          gnt_nxt   = '0;
        end
`ifdef SEG_PREEMPT_EN
        if (src_q != 2'd0 && bus.req[0]) begin
          state_nxt = RELEASE;
          gnt_nxt   = '0;
          pre_nxt   = 1'b1;
        end
`endif
      end
      RELEASE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  assign bus.gnt       = gnt_q;
  assign bus.src_id    = src_q;
  assign bus.disp_data = disp_q;
  assign bus.busy      = |gnt_q;
  assign bus.scan_tick = scan_tick_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
`timescale 1ns/1ps
// tb_seg_display_arbiter
//   Directed bench for seg_display_arbiter (PRESCALE = 4, DWELL = 8) with a
//   cycle-level reference model and hand-computed literal expectations.
module tb_seg_display_arbiter;
  localparam int PRESCALE = 4;
  localparam int DWELL    = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seg_display_if bus();

  seg_display_arbiter #(.PRESCALE(PRESCALE), .DWELL(DWELL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner index (-1 = nobody), cycles held so far,
  // cool-down edges before arbitration resumes, edges since reset.
  int          m_owner;
  int          m_held;
  int          m_cool;
  int          m_last;
  int          m_cyc;
  logic [15:0] m_disp;
  logic [1:0]  m_src;
  bit          m_pre;

  function automatic logic [15:0] word(input int i);
    case (i)
      0:       return bus.data0;
      1:       return bus.data1;
      2:       return bus.data2;
      default: return bus.data3;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1; m_held = 0; m_cool = 0; m_last = 3; m_cyc = 0;
      m_disp = 16'h0000; m_src = 2'd0; m_pre = 1'b0;
    end else begin
      m_cyc++;
      if (m_owner >= 0) begin
        bit pre;
        pre = 1'b0;
`ifdef SEG_PREEMPT_EN
        pre = (m_owner != 0) && bus.req[0];
`endif
        m_disp = word(m_owner);
        m_held++;
        if (m_held == DWELL || !bus.req[m_owner] || pre) begin
          m_owner = -1;
          m_cool  = 1;
          if (pre) m_pre = 1'b1;
        end
      end else if (m_cool > 0) begin
        m_cool--;
      end else if (bus.req != 4'b0000) begin
        int w;
        w = -1;
        for (int k = 1; k <= 4; k++)
          if (w < 0 && bus.req[(m_last + k) % 4]) w = (m_last + k) % 4;
        if (m_pre && bus.req[0]) w = 0;
        m_pre   = 1'b0;
        m_owner = w;
        m_held  = 0;
        m_src   = w[1:0];
        m_last  = w;
        m_disp  = word(w);
      end
    end
  end

  always @(negedge clk) begin
    logic [3:0] eg;
    eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    check("gnt",       32'(bus.gnt),       32'(eg));
    check("busy",      32'(bus.busy),      32'(|eg));
    check("gnt_onehot", 32'($onehot0(bus.gnt)), 32'd1);
    check("src_id",    32'(bus.src_id),    32'(m_src));
    check("disp_data", 32'(bus.disp_data), 32'(m_disp));
    check("scan_tick", 32'(bus.scan_tick), 32'(m_cyc > 0 && (m_cyc % PRESCALE) == 0));
  end

  task automatic drive_pt();
    @(negedge clk);
    #1;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [11:0] tmask;
    int          order[5];
    int          start[5];
    int          exp_order[5] = '{0, 1, 2, 3, 0};
    int          ng;
    int          n;
    logic [3:0]  pg;
    logic [15:0] first_disp;

    for (int i = 0; i < 5; i++) begin order[i] = -1; start[i] = -1; end
    first_disp = 16'h0;
    rst_n = 1'b0;
    bus.req = 4'b0000;
    bus.data0 = 16'h0; bus.data1 = 16'h0; bus.data2 = 16'h0; bus.data3 = 16'h0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_gnt",  32'(bus.gnt),       32'h0);
    check("rst_disp", 32'(bus.disp_data), 32'h0);
    check("rst_src",  32'(bus.src_id),    32'h0);
    check("rst_busy", 32'(bus.busy),      32'h0);
    check("rst_tick", 32'(bus.scan_tick), 32'h0);
    rst_n = 1'b1;

    // Prescaler: ticks after edges 4, 8, 12.
    tmask = '0;
    for (int c = 0; c < 12; c++) begin
      after_edge();
      tmask[c] = bus.scan_tick;
    end
    check("tick_pattern", 32'(tmask), 32'h888);
    check("idle_gnt",     32'(bus.gnt), 32'h0);
    check("idle_disp",    32'(bus.disp_data), 32'h0);

    // All four requesting: 0,1,2,3,0, each 8 cycles, 2-cycle gaps.
    drive_pt();
    bus.data0 = 16'hA000; bus.data1 = 16'hA111; bus.data2 = 16'hA222; bus.data3 = 16'hA333;
    bus.req = 4'b1111;
    ng = 0;
    pg = bus.gnt;
    for (int c = 1; c <= 60 && ng < 5; c++) begin
      after_edge();
      if (bus.gnt != 4'b0000 && pg == 4'b0000) begin
        if (ng == 0) first_disp = bus.disp_data;
        order[ng] = int'(bus.src_id);
        start[ng] = c;
        ng++;
      end
      pg = bus.gnt;
    end
    check("rr_count",         32'(ng),       32'd5);
    check("rr_first_latency", 32'(start[0]), 32'd1);
    check("rr_first_disp",    32'(first_disp), 32'hA000);
    for (int i = 0; i < 5; i++)
      check($sformatf("rr_order%0d", i), 32'(order[i]), 32'(exp_order[i]));
    for (int i = 1; i < 5; i++)
      check($sformatf("rr_spacing%0d", i), 32'(start[i] - start[i-1]), 32'd10);
    drive_pt();
    bus.req = 4'b0000;
    repeat (3) after_edge();
    check("rr_idle_gnt", 32'(bus.gnt), 32'h0);

    // Single source 1: 8-cycle hold, release, idle, re-grant.
    drive_pt();
    bus.data1 = 16'hBEEF;
    bus.req = 4'b0010;
    after_edge();
    check("beef_gnt",  32'(bus.gnt),       32'h2);
    check("beef_disp", 32'(bus.disp_data), 32'hBEEF);
    check("beef_src",  32'(bus.src_id),    32'd1);
    n = 1;
    for (int c = 0; c < 20 && bus.busy; c++) begin
      after_edge();
      if (bus.busy) n++;
    end
    check("beef_busy_len",    32'(n),       32'd8);
    check("beef_release_gnt", 32'(bus.gnt), 32'h0);
    after_edge();
    check("beef_gap_gnt",     32'(bus.gnt), 32'h0);
    after_edge();
    check("beef_regrant",     32'(bus.gnt), 32'h2);
    drive_pt();
    bus.req = 4'b0000;
    repeat (3) after_edge();

    // Source 2 live data, then early release at HOLD cycle 3.
    drive_pt();
    bus.data2 = 16'h1234;
    bus.req = 4'b0100;
    after_edge();
    check("live_gnt",   32'(bus.gnt),       32'h4);
    check("live_disp0", 32'(bus.disp_data), 32'h1234);
    drive_pt();
    bus.data2 = 16'h5678;
    after_edge();
    check("live_disp1", 32'(bus.disp_data), 32'h5678);
    after_edge();
    drive_pt();
    bus.req = 4'b0000;
    after_edge();
    check("live_rel_gnt",  32'(bus.gnt),       32'h0);
    check("live_rel_disp", 32'(bus.disp_data), 32'h5678);
    drive_pt();
    bus.data2 = 16'h9999;
    after_edge();
    check("live_frozen_disp", 32'(bus.disp_data), 32'h5678);
    after_edge();

    // Reset at HOLD cycle 4 clears outputs without a clock edge.
    drive_pt();
    bus.data2 = 16'hC0DE;
    bus.req = 4'b0100;
    after_edge();
    check("rh_gnt", 32'(bus.gnt), 32'h4);
    repeat (3) after_edge();
    check("rh_busy_before", 32'(bus.busy), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rh_gnt_cleared",  32'(bus.gnt),       32'h0);
    check("rh_busy_cleared", 32'(bus.busy),      32'h0);
    check("rh_disp_cleared", 32'(bus.disp_data), 32'h0);
    check("rh_src_cleared",  32'(bus.src_id),    32'h0);
    drive_pt();
    bus.req = 4'b1111;
    repeat (2) drive_pt();
    rst_n = 1'b1;
    after_edge();
    check("rh_next_gnt", 32'(bus.gnt),    32'h1);
    check("rh_next_src", 32'(bus.src_id), 32'd0);
    drive_pt();
    bus.req = 4'b0000;
    repeat (3) after_edge();

    // Source 3 holding, source 0 requests at HOLD cycle 2.
    drive_pt();
    bus.data3 = 16'h3333;
    bus.req = 4'b1000;
    after_edge();
    check("pe_gnt", 32'(bus.gnt), 32'h8);
    after_edge();
    drive_pt();
    bus.req = 4'b1001;
`ifdef SEG_PREEMPT_EN
    after_edge();
    check("pe_release_gnt", 32'(bus.gnt), 32'h0);
    after_edge();
    check("pe_gap_gnt",     32'(bus.gnt), 32'h0);
    after_edge();
    check("pe_src0_gnt",    32'(bus.gnt), 32'h1);
`else
    n = 2;
    for (int c = 0; c < 20 && bus.busy; c++) begin
      after_edge();
      if (bus.busy) n++;
    end
    check("pe_hold_len", 32'(n), 32'd8);
    after_edge();
    check("pe_gap_gnt",  32'(bus.gnt), 32'h0);
    after_edge();
    check("pe_next_gnt", 32'(bus.gnt), 32'h1);
`endif
    drive_pt();
    bus.req = 4'b0000;
    repeat (3) after_edge();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
